// File: rtl/mmio_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and address decode for the
// MMIO FIFO bank.
package mmio_fifo_pkg;

  // Register offsets inside one channel's window, and the window stride
  localparam int unsigned DATA_OFS   = 0;
  localparam int unsigned STATUS_OFS = 2;
  localparam int unsigned CH_STRIDE  = 4;

  // STATUS register layout; count lives in bits [COUNT_W-1:0]
  localparam int unsigned COUNT_W    = 11;
  localparam int unsigned EMPTY_BIT  = 32;
  localparam int unsigned FULL_BIT   = 33;
  localparam int unsigned OVF_BIT    = 34;
  localparam int unsigned UDF_BIT    = 35;

  // CTRL register fields
  localparam int unsigned FLUSH_LSB  = 0;
  localparam int unsigned CLR_LSB    = 16;

  localparam int unsigned TID_W      = 9;
  localparam int unsigned CH_IDX_W   = 3;

  typedef enum logic [1:0] {
    REG_MISS,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e             kind;
    logic [CH_IDX_W-1:0]   ch;
  } reg_hit_t;

  // Classify an MMIO address relative to the bank base. ctrl_ofs is the
  // offset of CTRL, i.e. the first address past the last channel window.
  function automatic reg_hit_t decode_addr(input logic [15:0] addr,
                                           input logic [15:0] base,
                                           input logic [15:0] ctrl_ofs);
    reg_hit_t    hit;
    logic [15:0] off;
    hit.kind = REG_MISS;
    hit.ch   = '0;
    off      = addr - base;
    if (addr >= base) begin
      if (off == ctrl_ofs) begin
        hit.kind = REG_CTRL;
      end else if (off < ctrl_ofs) begin
        hit.ch = off[4:2];
        if (off[1:0] == 2'(DATA_OFS))        hit.kind = REG_DATA;
        else if (off[1:0] == 2'(STATUS_OFS)) hit.kind = REG_STATUS;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/mmio_fifo_ch.sv
// One circular FIFO channel: push/pop/flush with a separately tracked count
// and sticky overflow/underflow flags.
module mmio_fifo_ch #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CNT_W  = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_push_data,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_ovf,
  output logic              o_udf,
  output logic              o_not_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_udf;
  logic              r_not_empty;

  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic              w_ovf_set;
  logic              w_udf_set;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  // Flush overrides both strobes. A pop frees a slot in the same cycle, so a
  // push to a full FIFO still lands when paired with a successful pop.
  assign w_do_pop  = i_pop  & ~i_flush & ~w_empty;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);
  assign w_ovf_set = i_push & ~i_flush & w_full & ~w_do_pop;
  assign w_udf_set = i_pop  & ~i_flush & w_empty;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    // NOTE: default first so every path assigns w_count_nxt; otherwise a latch is inferred.
    w_count_nxt = r_count;
    if (i_flush)                      w_count_nxt = '0;
    else if (w_do_push && !w_do_pop)  w_count_nxt = r_count + CNT_W'(1);
    else if (w_do_pop  && !w_do_push) w_count_nxt = r_count - CNT_W'(1);
  end

  // Pointers, count and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_not_empty <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_not_empty <= (w_count_nxt != '0);
      if (i_flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_do_push) r_tail <= r_tail + AW'(1);
        if (w_do_pop)  r_head <= r_head + AW'(1);
      end
      // A new event beats a clear in the same cycle
      if (w_ovf_set)  r_ovf <= 1'b1;
      else if (i_clr) r_ovf <= 1'b0;
      if (w_udf_set)  r_udf <= 1'b1;
      else if (i_clr) r_udf <= 1'b0;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; validity is carried entirely by count and pointers.
    if (w_do_push) r_mem[r_tail] <= i_push_data;
  end

  assign o_head      = r_mem[r_head];
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_ovf       = r_ovf;
  assign o_udf       = r_udf;
  assign o_not_empty = r_not_empty;

endmodule

// File: rtl/mmio_fifo_bank.sv
// MMIO-mapped bank of NUM_CH FIFOs: address decode, per-channel strobes and
// a registered read-response mux with TID echo.
module mmio_fifo_bank
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [15:0]       wr_addr,
  input  logic [63:0]       wr_data,
  input  logic              rd_valid,
  input  logic [15:0]       rd_addr,
  input  logic [TID_W-1:0]  rd_tid,
  output logic              rsp_valid,
  output logic [TID_W-1:0]  rsp_tid,
  output logic [63:0]       rsp_data,
  output logic [NUM_CH-1:0] not_empty
);

  localparam int unsigned  CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [15:0]  CTRL_OFS = 16'(NUM_CH * CH_STRIDE);

  reg_hit_t          w_wr_hit;
  reg_hit_t          w_rd_hit;
  logic              w_rd_hit_v;
  logic              w_ctrl_wr;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_flush;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_ovf;
  logic [NUM_CH-1:0] w_udf;
  logic [NUM_CH-1:0] w_not_empty;
  logic [DATA_W-1:0] w_head  [NUM_CH];
  logic [CNT_W-1:0]  w_count [NUM_CH];
  logic [63:0]       w_rsp_data;

  logic              r_rsp_valid;
  logic [TID_W-1:0]  r_rsp_tid;
  logic [63:0]       r_rsp_data;

  assign w_wr_hit   = decode_addr(wr_addr, BASE_ADDR, CTRL_OFS);
  assign w_rd_hit   = decode_addr(rd_addr, BASE_ADDR, CTRL_OFS);
  assign w_rd_hit_v = rd_valid & (w_rd_hit.kind != REG_MISS);
  assign w_ctrl_wr  = wr_valid & (w_wr_hit.kind == REG_CTRL);
  assign w_flush    = w_ctrl_wr ? wr_data[FLUSH_LSB +: NUM_CH] : '0;
  assign w_clr      = w_ctrl_wr ? wr_data[CLR_LSB   +: NUM_CH] : '0;

  // Per-channel push/pop strobes from the decoded DATA accesses
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_push[c] = wr_valid & (w_wr_hit.kind == REG_DATA) & (w_wr_hit.ch == CH_IDX_W'(c));
      w_pop[c]  = rd_valid & (w_rd_hit.kind == REG_DATA) & (w_rd_hit.ch == CH_IDX_W'(c));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mmio_fifo_ch #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push[g]),
      .i_pop       (w_pop[g]),
      .i_flush     (w_flush[g]),
      .i_clr       (w_clr[g]),
      .i_push_data (wr_data[DATA_W-1:0]),
      .o_head      (w_head[g]),
      .o_count     (w_count[g]),
      .o_full      (w_full[g]),
      .o_empty     (w_empty[g]),
      .o_ovf       (w_ovf[g]),
      .o_udf       (w_udf[g]),
      .o_not_empty (w_not_empty[g])
    );
  end

  // Read data selection; empty or flushed pops and CTRL reads return zero
  always_comb begin
    w_rsp_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_rd_hit.ch == CH_IDX_W'(c)) begin
        if (w_rd_hit.kind == REG_DATA) begin
          if (!w_flush[c] && !w_empty[c]) w_rsp_data[DATA_W-1:0] = w_head[c];
        end else if (w_rd_hit.kind == REG_STATUS) begin
          w_rsp_data[CNT_W-1:0] = w_count[c];
          w_rsp_data[EMPTY_BIT] = w_empty[c];
          w_rsp_data[FULL_BIT]  = w_full[c];
          w_rsp_data[OVF_BIT]   = w_ovf[c];
          w_rsp_data[UDF_BIT]   = w_udf[c];
        end
      end
    end
  end

  // Registered response: valid only for hits, payload held between hits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rd_hit_v;
      if (w_rd_hit_v) begin
        r_rsp_tid  <= rd_tid;
        r_rsp_data <= w_rsp_data;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_tid   = r_rsp_tid;
  assign rsp_data  = r_rsp_data;
  assign not_empty = w_not_empty;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Directed bench for mmio_fifo_bank: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences.
module tb_mmio_fifo_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 16;

  localparam logic [15:0] A_D0   = 16'h0020, A_S0 = 16'h0022;
  localparam logic [15:0] A_D1   = 16'h0024, A_S1 = 16'h0026;
  localparam logic [15:0] A_D2   = 16'h0028, A_S2 = 16'h002A;
  localparam logic [15:0] A_D3   = 16'h002C, A_S3 = 16'h002E;
  localparam logic [15:0] A_CTRL = 16'h0030, A_MISS = 16'h0032;

  localparam logic [63:0] ST_EMPTY = 64'h0000_0001_0000_0000;

  logic              clk;
  logic              rst;
  logic              wr_valid;
  logic [15:0]       wr_addr;
  logic [63:0]       wr_data;
  logic              rd_valid;
  logic [15:0]       rd_addr;
  logic [8:0]        rd_tid;
  logic              rsp_valid;
  logic [8:0]        rsp_tid;
  logic [63:0]       rsp_data;
  logic [NUM_CH-1:0] not_empty;

  int n_total = 0;
  int n_pass  = 0;
  logic [8:0] tid_ctr = 9'h001;

  mmio_fifo_bank #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (16'h0020)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_tid    (rd_tid),
    .rsp_valid (rsp_valid),
    .rsp_tid   (rsp_tid),
    .rsp_data  (rsp_data),
    .not_empty (not_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wv;
    logic [15:0] wa;
    logic [63:0] wd;
    bit          rv;
    logic [15:0] ra;
    bit          ev;
    logic [63:0] ed;
    logic [3:0]  ene;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(bit wv, logic [15:0] wa, logic [63:0] wd,
                              bit rv, logic [15:0] ra,
                              bit ev, logic [63:0] ed, logic [3:0] ene);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.rv = rv; v.ra = ra;
    v.ev = ev; v.ed = ed; v.ene = ene;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // One bus cycle: drive at negedge, outputs settled 1 time unit after posedge
  task automatic op(input bit wv, input logic [15:0] wa, input logic [63:0] wd,
                    input bit rv, input logic [15:0] ra, input logic [8:0] tid);
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rd_tid = tid;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] wa, input logic [63:0] wd);
    op(1'b1, wa, wd, 1'b0, 16'h0, 9'h0);
  endtask

  task automatic rd_check(input string name, input logic [15:0] ra, input logic [63:0] exp);
    logic [8:0] t;
    t = tid_ctr;
    tid_ctr = tid_ctr + 9'd37;
    op(1'b0, 16'h0, 64'h0, 1'b1, ra, t);
    check({name, ".valid"}, 64'(rsp_valid), 64'h1);
    check({name, ".tid"},   64'(rsp_tid),   64'(t));
    check({name, ".data"},  rsp_data,       exp);
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_tid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset.rsp_tid",   64'(rsp_tid),   64'h0);
    check("reset.rsp_data",  rsp_data,       64'h0);
    check("reset.not_empty", 64'(not_empty), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset status read with explicit TID
    op(1'b0, 16'h0, 64'h0, 1'b1, A_S0, 9'h1A5);
    check("rst_status.valid", 64'(rsp_valid), 64'h1);
    check("rst_status.tid",   64'(rsp_tid),   64'h1A5);
    check("rst_status.data",  rsp_data,       ST_EMPTY);
    check("rst_status.ne",    64'(not_empty), 64'h0);

    // ---------------- Vector table ----------------
    vecs[0]  = mk(1, A_D1, 64'd1, 0, 0,      0, 0, 4'b0010);
    vecs[1]  = mk(1, A_D1, 64'd2, 0, 0,      0, 0, 4'b0010);
    vecs[2]  = mk(1, A_D1, 64'd3, 0, 0,      0, 0, 4'b0010);
    vecs[3]  = mk(0, 0, 0,        1, A_S1,   1, 64'd3, 4'b0010);
    vecs[4]  = mk(0, 0, 0,        1, A_D1,   1, 64'd1, 4'b0010);
    vecs[5]  = mk(0, 0, 0,        1, A_D1,   1, 64'd2, 4'b0010);
    vecs[6]  = mk(0, 0, 0,        1, A_D1,   1, 64'd3, 4'b0000);
    vecs[7]  = mk(0, 0, 0,        1, A_S1,   1, ST_EMPTY, 4'b0000);
    vecs[8]  = mk(0, 0, 0,        1, A_CTRL, 1, 64'd0, 4'b0000);
    vecs[9]  = mk(0, 0, 0,        1, A_MISS, 0, 0, 4'b0000);
    vecs[10] = mk(1, A_D0, 64'hAA, 0, 0,     0, 0, 4'b0001);
    vecs[11] = mk(0, 0, 0,        1, A_S1,   1, ST_EMPTY, 4'b0001);
    vecs[12] = mk(0, 0, 0,        1, A_D0,   1, 64'hAA, 4'b0000);
    vecs[13] = mk(0, 0, 0,        1, A_D3,   1, 64'd0, 4'b0000);
    vecs[14] = mk(0, 0, 0,        1, A_S3,   1, 64'h0000_0009_0000_0000, 4'b0000);
    vecs[15] = mk(1, A_CTRL, 64'h0008_0000, 0, 0, 0, 0, 4'b0000);
    vecs[16] = mk(0, 0, 0,        1, A_S3,   1, ST_EMPTY, 4'b0000);
    vecs[17] = mk(1, A_D3, 64'h33, 0, 0,     0, 0, 4'b1000);
    vecs[18] = mk(1, A_D3, 64'h44, 0, 0,     0, 0, 4'b1000);
    vecs[19] = mk(0, 0, 0,        1, A_S3,   1, 64'd2, 4'b1000);
    vecs[20] = mk(1, A_CTRL, 64'h0000_0008, 0, 0, 0, 0, 4'b0000);
    vecs[21] = mk(0, 0, 0,        1, A_S3,   1, ST_EMPTY, 4'b0000);
    vecs[22] = mk(1, A_S0, 64'hFF, 0, 0,     0, 0, 4'b0000);
    vecs[23] = mk(0, 0, 0,        1, A_S0,   1, ST_EMPTY, 4'b0000);
    // Pop-on-empty with simultaneous push: returns 0, udf set, push kept
    vecs[24] = mk(1, A_D2, 64'h55, 1, A_D2,  1, 64'd0, 4'b0100);
    vecs[25] = mk(0, 0, 0,        1, A_S2,   1, 64'h0000_0008_0000_0001, 4'b0100);
    vecs[26] = mk(0, 0, 0,        1, A_D2,   1, 64'h55, 4'b0000);
    // STATUS read sees pre-clear flags in the clearing cycle
    vecs[27] = mk(1, A_CTRL, 64'h0004_0000, 1, A_S2, 1, 64'h0000_0009_0000_0000, 4'b0000);
    vecs[28] = mk(0, 0, 0,        1, A_S2,   1, ST_EMPTY, 4'b0000);

    for (int i = 0; i < 29; i++) begin
      logic [8:0] t;
      t = 9'(i * 7 + 3);
      op(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, t);
      check($sformatf("vec%0d.valid", i), 64'(rsp_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d.tid", i),  64'(rsp_tid), 64'(t));
        check($sformatf("vec%0d.data", i), rsp_data,     vecs[i].ed);
      end
      check($sformatf("vec%0d.ne", i), 64'(not_empty), 64'(vecs[i].ene));
    end

    // ---------------- Full, overflow and pointer wrap on ch2 ----------------
    for (int i = 0; i < 5; i++) wr(A_D2, 64'(200 + i));
    for (int i = 0; i < 5; i++) rd_check($sformatf("pre_wrap%0d", i), A_D2, 64'(200 + i));
    for (int i = 0; i <= DEPTH; i++) wr(A_D2, 64'(100 + i));
    rd_check("ovf_status", A_S2, 64'h0000_0006_0000_0010);
    for (int i = 0; i < DEPTH; i++) rd_check($sformatf("drain%0d", i), A_D2, 64'(100 + i));
    rd_check("ovf_drained", A_S2, 64'h0000_0005_0000_0000);
    wr(A_CTRL, 64'h0004_0000);
    rd_check("ovf_cleared", A_S2, ST_EMPTY);

    // ---------------- Set beats clear in the same cycle (ch3 udf) ----------------
    op(1'b1, A_CTRL, 64'h0008_0000, 1'b1, A_D3, 9'h0C3);
    check("setclr.data", rsp_data, 64'h0);
    rd_check("setclr_status", A_S3, 64'h0000_0009_0000_0000);
    wr(A_CTRL, 64'h0008_0000);

    // ---------------- Simultaneous push and pop on full ch0 ----------------
    for (int i = 0; i < DEPTH; i++) wr(A_D0, 64'(300 + i));
    op(1'b1, A_D0, 64'd999, 1'b1, A_D0, 9'h111);
    check("pushpop.valid", 64'(rsp_valid), 64'h1);
    check("pushpop.data",  rsp_data,       64'd300);
    rd_check("pushpop_status", A_S0, 64'h0000_0002_0000_0010);
    for (int i = 1; i < DEPTH; i++) rd_check($sformatf("pp_drain%0d", i), A_D0, 64'(300 + i));
    rd_check("pp_last", A_D0, 64'd999);
    rd_check("pp_empty", A_S0, ST_EMPTY);

    // ---------------- Flush wins over a pop in the same cycle ----------------
    wr(A_D1, 64'h11);
    op(1'b1, A_CTRL, 64'h0000_0002, 1'b1, A_D1, 9'h022);
    check("flushpop.data", rsp_data, 64'h0);
    check("flushpop.ne",   64'(not_empty), 64'h0);
    rd_check("flushpop_status", A_S1, ST_EMPTY);

    // ---------------- Reset in the middle of a pending read ----------------
    wr(A_D0, 64'h77);
    check("prerst.ne", 64'(not_empty), 64'h1);
    @(negedge clk);
    rd_valid = 1'b1; rd_addr = A_S0; rd_tid = 9'h0AB;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.valid", 64'(rsp_valid), 64'h0);
    check("midrst.ne",    64'(not_empty), 64'h0);
    rd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_check("postrst_status", A_S0, ST_EMPTY);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_bank.md
# mmio_fifo_bank

Multi-channel MMIO-mapped FIFO bank that sits behind the AFU's CCI-P MMIO decode and replaces the single user-register FIFO. It provides NUM_CH independent circular FIFOs of parametrised width and depth. Host writes push data and host reads pop data. The block adds per-channel status, sticky overflow/underflow flags and a control register for flush and flag-clear. Read responses return one cycle after the request, with the TID carried through.

## Interface
- NUM_CH, 4: number of FIFO channels (1..8).
- DATA_W, 64: FIFO entry width (1..64); narrower data is zero-extended on read.
- DEPTH, 16: entries per channel; must be a power of two, 2..1024.
- BASE_ADDR, 16'h0020: MMIO address of channel 0 data register.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  MMIO write strobe (decoded mmioWrValid).
- wr_addr  in  16  MMIO write address.
- wr_data  in  64  MMIO write data.
- rd_valid  in  1  MMIO read strobe (decoded mmioRdValid).
- rd_addr  in  16  MMIO read address.
- rd_tid  in  9  read transaction ID.
- rsp_valid  out  1  read response valid; high only when the read address hit this block.
- rsp_tid  out  9  TID echoed with the response.
- rsp_data  out  64  response data.
- not_empty  out  NUM_CH  per-channel non-empty flag, registered.

## Operation
- Address map for channel c: DATA at BASE_ADDR+4c, STATUS at BASE_ADDR+4c+2.
- The CTRL register is at BASE_ADDR+4*NUM_CH.
- Any other address is a miss: the block produces no response and has no side effect.
- **DATA write:** pushes wr_data[DATA_W-1:0].
  - If the channel is full, the data is dropped, the channel's sticky ovf is set, and the count is unchanged.
- **DATA read:** returns the head entry and pops it.
  - If the channel is empty, the block returns 0, sets sticky udf, and leaves the pointers unchanged.
- **STATUS read** (no side effect):
  - bits [10:0] = count (0..DEPTH).
  - bit 32 = empty.
  - bit 33 = full.
  - bit 34 = ovf.
  - bit 35 = udf.
  - All other bits are 0.
- **STATUS write:** ignored.
- **CTRL write:**
  - wr_data[NUM_CH-1:0] is the flush mask: count goes to 0 and the pointers to 0.
  - wr_data[16+NUM_CH-1:16] is the flag-clear mask: ovf and udf go to 0.
- **CTRL read:** returns 0.
- **Pointers:** head and tail are log2(DEPTH) bits and wrap modulo DEPTH. The count is tracked separately, log2(DEPTH)+1 bits wide.
- **Simultaneous push and pop on the same channel** (independent strobes in one cycle):
  - Both take effect and the count is unchanged.
  - Push-on-full with a simultaneous pop succeeds, with no ovf.
  - Pop-on-empty with a simultaneous push returns 0, sets udf, and the push is accepted (count = 1).
- **Flush in the same cycle as a push or pop to the same channel:** flush wins, the push is discarded, and the pop returns 0 without setting udf.
- **Flag clear in the same cycle as a new ovf/udf event:** the set wins.

## Timing
- All outputs are registered.
- rsp_valid, rsp_tid and rsp_data appear exactly one cycle after rd_valid. The block supports back-to-back reads every cycle.
- A pop's pointer and count update is visible to a read issued in the next cycle.
- A push is visible to a read one cycle after wr_valid.
- Reset values:
  - rsp_valid=0, rsp_tid=0, rsp_data=0, not_empty=0.
  - All counts, pointers and flags are 0.
  - Storage contents are don't-care and are not reset.
- Reset mid-operation clears all state immediately. Any read pending in that cycle gets no response.
- rsp_valid deasserts in the cycle after a response unless there is a new hit.

## Structure
- Package mmio_fifo_pkg holds:
  - register offsets (DATA_OFS=0, STATUS_OFS=2, CH_STRIDE=4);
  - STATUS bit positions (EMPTY_BIT=32, FULL_BIT=33, OVF_BIT=34, UDF_BIT=35);
  - CTRL field offsets (FLUSH_LSB=0, CLR_LSB=16);
  - the TID width (9).
- Sub-module mmio_fifo_ch: one circular buffer with push, pop, flush, clr, count, full, empty, ovf, udf and head data. Instantiate it NUM_CH times via generate.
- The top level does address decode, the per-channel strobes and the registered response mux.

## Test plan
- **Reset state:** after reset, a STATUS read of ch0 returns 64'h0000_0001_0000_0000 (empty) with TID echoed one cycle later; not_empty=0.
- **FIFO order:** push 1,2,3 to ch1, then read ch1 DATA three times: returns 1, 2, 3. STATUS count goes 3→0. not_empty[1] falls after the last pop.
- **Full and overflow:** push DEPTH+1 values to ch2. The last value is dropped, STATUS shows full=1, ovf=1, count=DEPTH. Draining returns the first DEPTH values in order, including across a pointer wrap.
- **Underflow and clear:** read an empty ch3 DATA: returns 0 and udf=1. CTRL write 64'h0008_0000 clears udf. CTRL write 64'h0000_0008 flushes ch3 to count 0.
- **Simultaneous push and pop:** with ch0 full, a push and pop in the same cycle: pop returns the oldest entry, count stays DEPTH, no ovf.
- **Miss and isolation:** a read of BASE_ADDR+4*NUM_CH+2 gives no rsp_valid. A write to ch0 DATA leaves the ch1 count unchanged.
